event_fifo: RTL

EVENT_FIFO -- requirements
Module: event_fifo

---
 rtl/event_fifo_pkg.sv | 26 ++
 rtl/event_fifo_mem.sv | 37 +++
 rtl/event_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/event_fifo_pkg.sv
// Shared definitions for the event FIFO: register offsets, bit positions,
// the 64-bit stored entry and a small saturation helper.
package event_fifo_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_LEVEL  = 2'd2;
   localparam logic [1:0] REG_DROPS  = 2'd3;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_CLEAR  = 1;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_OVF   = 2;

   typedef struct packed {
      logic [31:0] evt_time;
      logic [31:0] signals;
   } entry_t;

   function automatic logic [7:0] sat8(input logic [31:0] v);
      return (v > 32'd255) ? 8'hFF : v[7:0];
   endfunction

endpackage

// File: rtl/event_fifo_mem.sv
// Simple dual-port DEPTH x 64 RAM, synchronous write and synchronous read.
// Ports: clk, reset (clears only the read register), we/waddr/wdata, re/raddr/rdata.
module event_fifo_mem
   import event_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // The read register doubles as the export register, so it holds its
   // value unless a load is requested.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/event_fifo.sv
// Timestamp/signal-count event FIFO between the counter and the Ethernet side,
// with a 4-register control window on the command bus.
// Ports: clock50Mhz, reset; addr/data/write/data_out (command bus);
//        in_valid/in_time/in_signals (counter); cread/time_export/
//        signals_export (eth); fifo_empty/fifo_full (status).
module event_fifo
   import event_fifo_pkg::*;
#(
   parameter int         DEPTH     = 16,
   parameter logic [7:0] BASE_ADDR = 8'h40
) (
   input  logic        clock50Mhz,
   input  logic        reset,
   input  logic [7:0]  addr,
   input  logic [7:0]  data,
   input  logic        write,
   output logic [7:0]  data_out,
   input  logic        in_valid,
   input  logic [31:0] in_time,
   input  logic [31:0] in_signals,
   input  logic        cread,
   output logic [31:0] time_export,
   output logic [31:0] signals_export,
   output logic        fifo_empty,
   output logic        fifo_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [LW-1:0] level;
   logic [LW-1:0] level_nxt;
   logic          enable;
   logic          overflow;
   logic [7:0]    drops;
   logic          cread_q;
   logic          armed;
   logic          load_q;
   logic          load_nxt;

   logic          in_win;
   logic [1:0]    off;
   logic          ctrl_wr;
   logic          clear;
   logic          is_empty;
   logic          is_full;
   logic          pop_rise;
   logic          pop;
   logic          push_req;
   logic          push;
   logic          drop;
   entry_t        head;
   logic          unused_data;

   assign unused_data = ^data[7:2];

   // Window compare in 9 bits so a base near 8'hFF cannot wrap.
   assign in_win = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, addr} < ({1'b0, BASE_ADDR} + 9'd4));
   assign off     = addr[1:0] - BASE_ADDR[1:0];
   assign ctrl_wr = write && in_win && (off == REG_CTRL);
   assign clear   = ctrl_wr && data[CTRL_CLEAR];

   assign is_empty = (level == '0);
   assign is_full  = (level == LW'(DEPTH));

   // armed stays low while cread has been high since reset, so a request
   // held across reset release does not look like a new edge.
   assign pop_rise = cread && !cread_q && armed;
   assign pop      = pop_rise && !is_empty && !clear;
   assign push_req = in_valid && enable && !clear;
   assign push     = push_req && (!is_full || pop);
   assign drop     = push_req && is_full && !pop;

   always_comb begin
      level_nxt = level;
      if (clear) begin
         level_nxt = '0;
      end else if (push && !pop) begin
         level_nxt = level + LW'(1);
      end else if (pop && !push) begin
         level_nxt = level - LW'(1);
      end
   end

   // The head is re-read one cycle after it changes; by then any write to
   // that slot has landed. An emptying pop leaves the export untouched.
   assign load_nxt = !clear &&
                     ((push && is_empty) || (pop && (level_nxt != '0)));

   always_ff @(posedge clock50Mhz) begin
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         level      <= '0;
         enable     <= 1'b0;
         overflow   <= 1'b0;
         drops      <= '0;
         cread_q    <= 1'b0;
         armed      <= !cread;
         load_q     <= 1'b0;
         fifo_empty <= 1'b1;
         fifo_full  <= 1'b0;
      end else begin
         cread_q <= cread;
         armed   <= armed || !cread;
         if (ctrl_wr) begin
            enable <= data[CTRL_ENABLE];
         end
         if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            drops    <= '0;
         end else begin
            if (push) begin
               wptr <= wptr + AW'(1);
            end
            if (pop) begin
               rptr <= rptr + AW'(1);
            end
            if (drop) begin
               overflow <= 1'b1;
               if (drops != 8'hFF) begin
                  drops <= drops + 8'd1;
               end
            end
         end
         level      <= level_nxt;
         load_q     <= load_nxt;
         fifo_empty <= (level_nxt == '0);
         fifo_full  <= (level_nxt == LW'(DEPTH));
      end
   end

   event_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clock50Mhz),
      .reset (reset),
      .we    (push),
      .waddr (wptr),
      .wdata ({in_time, in_signals}),
      .re    (load_q),
      .raddr (rptr),
      .rdata (head)
   );

   assign time_export    = head.evt_time;
   assign signals_export = head.signals;

   always_comb begin
      data_out = 8'h00;
      if (in_win) begin
         unique case (off)
            REG_CTRL:   data_out[CTRL_ENABLE] = enable;
            REG_STATUS: begin
               data_out[STAT_EMPTY] = fifo_empty;
               data_out[STAT_FULL]  = fifo_full;
               data_out[STAT_OVF]   = overflow;
            end
            REG_LEVEL:  data_out = sat8(32'(level));
            REG_DROPS:  data_out = drops;
         endcase
      end
   end

endmodule
